// File: rtl/par_serializer_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial sequencer.
package par_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [2:0] SEL_FIRST_LSB = 3'd0;
  localparam logic [2:0] SEL_LAST_LSB  = 3'd7;
  localparam int         GAP_W         = 4;

  function automatic logic [2:0] sel_start(input logic lsb_first);
    return lsb_first ? SEL_FIRST_LSB : SEL_LAST_LSB;
  endfunction

  function automatic logic [2:0] sel_end(input logic lsb_first);
    return lsb_first ? SEL_LAST_LSB : SEL_FIRST_LSB;
  endfunction

endpackage

// File: rtl/par_serializer8_bit_select8.sv
// Purely combinational 8:1 bit selector.
module bit_select8 (
  input  logic [7:0] in_i,
  input  logic [2:0] s_i,
  output logic       out_o
);

  assign out_o = in_i[s_i];

endmodule

// File: rtl/par_serializer8.sv
// Parallel-in serial-out sequencer: accepts one byte over valid/ready and
// walks a 3-bit select index across it, one bit per downstream beat.
module par_serializer8
  import par_serializer_pkg::*;
#(
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       ser_ready_i,
  output logic       ser_out_o,
  output logic       ser_valid_o,
  output logic       ser_first_o,
  output logic       ser_last_o,
  output logic [2:0] sel_o,
  output logic       busy_o
);

  localparam logic [2:0]       SEL_START = sel_start(LSB_FIRST);
  localparam logic [2:0]       SEL_END   = sel_end(LSB_FIRST);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 32'd0);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       word_q, word_d;
  logic [2:0]       sel_q, sel_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic in_shift_s;
  logic at_end_s;
  logic accept_s;

  assign in_shift_s = (state_q == SHIFT);
  assign at_end_s   = (sel_q == SEL_END);

  // The last-beat term is the only combinational path from an input (ser_ready_i) to an output.
  assign in_ready_o = rst_n & ((state_q == IDLE) |
                               (in_shift_s & HAS_GAP == 1'b0 & at_end_s & ser_ready_i));
  assign accept_s   = in_valid_i & in_ready_o;

  assign ser_valid_o = in_shift_s;
  assign ser_first_o = in_shift_s & (sel_q == SEL_START);
  assign ser_last_o  = in_shift_s & at_end_s;
  assign sel_o       = sel_q;
  assign busy_o      = (state_q != IDLE);

  bit_select8 u_bit_select8 (
    .in_i  (word_q),
    .s_i   (sel_q),
    .out_o (ser_out_o)
  );

  // State, held word, select index and gap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= 8'd0;
      sel_q   <= SEL_START;
      gap_q   <= {GAP_W{1'b0}};
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic; sel is always reloaded to its start value on leaving SHIFT.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          word_d  = in_data_i;
          sel_d   = SEL_START;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ser_ready_i) begin
          if (at_end_s) begin
            sel_d = SEL_START;
            if (HAS_GAP) begin
              gap_d   = GAP_LOAD;
              state_d = GAP;
            end else if (accept_s) begin
              word_d  = in_data_i;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else if (LSB_FIRST) begin
            sel_d = sel_q + 3'd1;
          end else begin
            sel_d = sel_q - 3'd1;
          end
        end else begin
          sel_d = sel_q;
        end
      end
      GAP: begin
        if (gap_q <= {{(GAP_W-1){1'b0}}, 1'b1}) begin
          gap_d   = {GAP_W{1'b0}};
          state_d = IDLE;
        end else begin
          gap_d = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_START;
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_par_serializer8.sv
// Scoreboard bench: three instances (LSB-first, MSB-first, LSB-first with a 2-cycle gap).
module tb_par_serializer8;

  typedef struct packed {
    logic       b;
    logic       first;
    logic       last;
    logic [2:0] sel;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [3];
  logic [7:0] in_data   [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       ser_ready [3];
  logic       ser_out   [3];
  logic       ser_valid [3];
  logic       ser_first [3];
  logic       ser_last  [3];
  logic [2:0] sel       [3];
  logic       busy      [3];

  exp_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;
  int   vcnt [3] = '{0, 0, 0};
  int   irp  [3] = '{0, 0, 0};
  int   cyc  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    par_serializer8 #(
      .LSB_FIRST  (g != 1),
      .GAP_CYCLES ((g == 2) ? 32'd2 : 32'd0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .in_data_i   (in_data[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .ser_ready_i (ser_ready[g]),
      .ser_out_o   (ser_out[g]),
      .ser_valid_o (ser_valid[g]),
      .ser_first_o (ser_first[g]),
      .ser_last_o  (ser_last[g]),
      .sel_o       (sel[g]),
      .busy_o      (busy[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Expected bit stream for one word on instance k (instance 1 is MSB-first).
  task automatic push_word(input int k, input logic [7:0] w);
    exp_t e;
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx     = (k != 1) ? 3'(i) : 3'(7 - i);
      e.b     = w[idx];
      e.first = (i == 0);
      e.last  = (i == 7);
      e.sel   = idx;
      exp_q[k].push_back(e);
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    if (ser_valid[k] === 1'b1) begin
      vcnt[k]++;
      if (in_ready[k] === 1'b1) irp[k]++;
      if (exp_q[k].size() == 0) begin
        chk($sformatf("unexpected_bit_%0d", k), 1, 0);
      end else begin
        e = exp_q[k][0];
        chk($sformatf("ser_out_%0d", k), int'(ser_out[k]), int'(e.b));
        chk($sformatf("ser_first_%0d", k), int'(ser_first[k]), int'(e.first));
        chk($sformatf("ser_last_%0d", k), int'(ser_last[k]), int'(e.last));
        chk($sformatf("sel_%0d", k), int'(sel[k]), int'(e.sel));
        if (ser_ready[k] === 1'b1) void'(exp_q[k].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] w, input bit hold, output int t);
    bit got;
    got = 1'b0;
    t   = 0;
    in_data[k]  = w;
    in_valid[k] = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (in_ready[k] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk($sformatf("accept_timeout_%0d", k), 0, 1);
      in_valid[k] = 1'b0;
    end else begin
      push_word(k, w);
      @(posedge clk);
      #1;
      t = cyc;
      if (!hold) in_valid[k] = 1'b0;
      @(negedge clk);
      chk($sformatf("latency_valid_%0d", k), int'(ser_valid[k]), 1);
      chk($sformatf("latency_first_%0d", k), int'(ser_first[k]), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int v0, r0, t1, t2;
    for (int k = 0; k < 3; k++) begin
      rst_n[k]     = 1'b0;
      in_data[k]   = 8'd0;
      in_valid[k]  = 1'b0;
      ser_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_%0d", k), int'(in_ready[k]), 0);
      chk($sformatf("rst_ser_valid_%0d", k), int'(ser_valid[k]), 0);
      chk($sformatf("rst_busy_%0d", k), int'(busy[k]), 0);
      chk($sformatf("rst_ser_out_%0d", k), int'(ser_out[k]), 0);
      chk($sformatf("rst_flags_%0d", k), int'({ser_first[k], ser_last[k]}), 0);
      chk($sformatf("rst_sel_%0d", k), int'(sel[k]), (k == 1) ? 7 : 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("rel_in_ready_%0d", k), int'(in_ready[k]), 1);

    // 8'hAA LSB first: 0,1,0,1,0,1,0,1
    wait_cyc(1);
    v0 = vcnt[0];
    send(0, 8'hAA, 1'b0, t1);
    wait_cyc(10);
    chk("lsb_valid_cycles", vcnt[0] - v0, 8);

    // 8'hAA MSB first: 1,0,1,0,1,0,1,0
    v0 = vcnt[1];
    send(1, 8'hAA, 1'b0, t1);
    wait_cyc(10);
    chk("msb_valid_cycles", vcnt[1] - v0, 8);

    // Three-cycle stall at sel=3
    v0 = vcnt[0];
    send(0, 8'h5C, 1'b0, t1);
    repeat (3) @(posedge clk);
    #1;
    ser_ready[0] = 1'b0;
    @(negedge clk);
    chk("stall_sel", int'(sel[0]), 3);
    chk("stall_valid", int'(ser_valid[0]), 1);
    repeat (3) @(posedge clk);
    #1;
    ser_ready[0] = 1'b1;
    wait_cyc(10);
    chk("stall_valid_cycles", vcnt[0] - v0, 11);

    // Back-to-back F0 then 0F with no gap
    v0 = vcnt[0];
    r0 = irp[0];
    send(0, 8'hF0, 1'b1, t1);
    send(0, 8'h0F, 1'b0, t2);
    chk("b2b_spacing", t2 - t1, 8);
    wait_cyc(10);
    chk("b2b_valid_cycles", vcnt[0] - v0, 16);
    chk("b2b_ready_pulses", irp[0] - r0, 2);

    // Gap of 2 cycles: 3 idle cycles between words
    v0 = vcnt[2];
    r0 = irp[2];
    send(2, 8'h3C, 1'b1, t1);
    send(2, 8'hC3, 1'b0, t2);
    chk("gap_spacing", t2 - t1, 11);
    wait_cyc(15);
    chk("gap_valid_cycles", vcnt[2] - v0, 16);
    chk("gap_ready_in_shift", irp[2] - r0, 0);

    // Reset mid-word at sel=4
    send(0, 8'h96, 1'b0, t1);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_sel", int'(sel[0]), 4);
    rst_n[0] = 1'b0;
    #1;
    exp_q[0].delete();
    chk("abort_valid", int'(ser_valid[0]), 0);
    chk("abort_sel", int'(sel[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_in_ready", int'(in_ready[0]), 0);
    chk("abort_ser_out", int'(ser_out[0]), 0);
    chk("abort_flags", int'({ser_first[0], ser_last[0]}), 0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("abort_rel_in_ready", int'(in_ready[0]), 1);
    chk("abort_rel_sel", int'(sel[0]), 0);
    wait_cyc(1);
    v0 = vcnt[0];
    send(0, 8'h81, 1'b0, t1);
    wait_cyc(10);
    chk("post_abort_valid_cycles", vcnt[0] - v0, 8);

    for (int k = 0; k < 3; k++) chk($sformatf("queue_drained_%0d", k), exp_q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_serializer8.md
# par_serializer8

Parallel-in, serial-out sequencer that accepts an 8-bit word over a valid/ready handshake and emits it one bit per accepted beat. It walks a 3-bit select index across the held word through an 8:1 bit selector. It sits upstream of serial consumers (shift links, LED/bit-bang drivers) and exposes the live select index for debug and for driving an external 8:1 mux in lockstep.

## Interface
- LSB_FIRST, 1, 1: select order 0→7; 0: order 7→0
- GAP_CYCLES, 0, idle cycles forced between words (0–15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  parallel word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a word this cycle
- ser_ready  in  1  downstream accepts current bit
- ser_out  out  1  current serial bit
- ser_valid  out  1  ser_out is valid
- ser_first  out  1  current bit is the first bit of the word
- ser_last  out  1  current bit is the last bit of the word
- sel  out  3  current select index into the held word
- busy  out  1  high in SHIFT or GAP state

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid & in_ready: latch in_data into word_q, load sel with its start value (0 if LSB_FIRST, else 7), go to SHIFT.
- SHIFT:
  - ser_valid=1; ser_out=word_q[sel].
  - ser_first is high at the start index; ser_last is high at the end index (7 if LSB_FIRST, else 0).
  - A beat is ser_valid & ser_ready. On a beat, sel steps ±1. Without ser_ready, sel, ser_out and flags hold stable.
- Leaving SHIFT on the last beat:
  - GAP_CYCLES>0: go to GAP and load gap counter with GAP_CYCLES.
  - GAP_CYCLES=0 with in_valid high: in_ready=1 combinationally (in_ready = ser_last & ser_ready). Load the new word and restart sel for a back-to-back transfer with no bubble.
  - Otherwise: go to IDLE.
- GAP: ser_valid=0, in_ready=0. Counter decrements each cycle. At 1, go to IDLE.
- word_q does not change while in SHIFT; in_data changes are ignored until in_ready.
- sel wraps only through reload, never arithmetically past 0/7.

## Timing
- Reset values (asynchronous, active-low):
  - State IDLE, word_q=0, sel=start value (0 if LSB_FIRST, else 7), gap counter 0.
  - ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, in_ready=1 after reset release. in_ready is 0 while rst_n=0.
- Accept at edge k → ser_valid=1 with the first bit in the cycle after edge k (latency 1).
- A word with ser_ready held high occupies exactly 8 cycles of ser_valid. Back-to-back throughput is 8 cycles/word when GAP_CYCLES=0, else 8+GAP_CYCLES+1 (GAP plus the IDLE accept cycle).
- ser_out, ser_first, ser_last and sel are derived from registered state only. The only combinational input→output path is ser_ready→in_ready.
- Reset asserted mid-word: transfer aborted, outputs return to reset values immediately, no partial word resumes.
- in_valid while busy (outside the last-beat window): not accepted, no side effect.

## Structure
- Package par_serializer_pkg:
  - state enum (IDLE/SHIFT/GAP)
  - constants SEL_FIRST_LSB=3'd0, SEL_LAST_LSB=3'd7
  - GAP counter width 4
- One sub-module, bit_select8: purely combinational 8:1 selector (in[7:0], s[2:0] → out). Instantiated on word_q/sel.
- Everything else, including the FSM, select counter and gap counter, lives in the top module.

## Test plan
- Reset then load 8'b10101010, LSB_FIRST=1, ser_ready=1 → ser_out 0,1,0,1,0,1,0,1 on 8 consecutive cycles; sel 0..7; ser_first with sel=0, ser_last with sel=7.
- Same word, LSB_FIRST=0 → ser_out 1,0,1,0,1,0,1,0; sel 7..0.
- ser_ready low for 3 cycles at sel=3 → sel, ser_out, ser_valid hold for those 3 cycles; word completes in 11 cycles total.
- GAP_CYCLES=0, in_valid held high with words 8'hF0 then 8'h0F → 16 contiguous valid bits, in_ready pulses only on the last beat of each word.
- GAP_CYCLES=2 with back-to-back words → exactly 3 cycles of ser_valid=0 between words.
- rst_n pulled low at sel=4 → all outputs at reset values the same cycle; after release in_ready=1 and the next word starts at sel=0.
